// File: rtl/mem_access_unit_pkg.sv
// Shared constants and decode helper for the Y86 handshaked memory stage.
// Holds instruction codes, status codes, FSM encodings and the icode-to-access mapping.
package mem_access_unit_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVL = 4'h4;
    localparam logic [3:0] I_MRMOVL = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHL  = 4'hA;
    localparam logic [3:0] I_POPL   = 4'hB;

    localparam logic [1:0] SAOK = 2'b01;
    localparam logic [1:0] SADR = 2'b10;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_REQ    = 2'b01;
    localparam logic [1:0] ST_WAIT_R = 2'b10;
    localparam logic [1:0] ST_DONE   = 2'b11;

    typedef enum logic [0:0] {ASEL_VALE = 1'b0, ASEL_VALA = 1'b1} addr_sel_e;
    typedef enum logic [0:0] {WSEL_VALA = 1'b0, WSEL_VALP = 1'b1} wdata_sel_e;

    typedef struct packed {
        logic       rd;
        logic       wr;
        addr_sel_e  asel;
        wdata_sel_e wsel;
    } mem_op_t;

    // Stack pops/returns address through valA; everything else addresses through valE.
    function automatic mem_op_t decode_icode(input logic [NIBBLE_W-1:0] icode);
        mem_op_t op;
        op = '{rd: 1'b0, wr: 1'b0, asel: ASEL_VALE, wsel: WSEL_VALA};
        case (icode)
            I_RMMOVL, I_PUSHL: op.wr = 1'b1;
            I_MRMOVL:          op.rd = 1'b1;
            I_CALL: begin
                op.wr   = 1'b1;
                op.wsel = WSEL_VALP;
            end
            I_RET, I_POPL: begin
                op.rd   = 1'b1;
                op.asel = ASEL_VALA;
            end
            default: op.rd = 1'b0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request port: req/gnt handshake for the command, rvalid for read data.
interface mem_access_unit_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit_mem_op_decode.sv
// Combinational icode decode: read/write enables plus selected address and write data.
module mem_op_decode
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [NIBBLE_W-1:0] icode,
    input  logic [DATA_W-1:0]   val_a,
    input  logic [DATA_W-1:0]   val_p,
    input  logic [DATA_W-1:0]   val_e,
    output logic                rd,
    output logic                wr,
    output logic [DATA_W-1:0]   addr,
    output logic [DATA_W-1:0]   wdata
);
    mem_op_t op_s;

    // Map the instruction onto its memory access and operand selections.
    always_comb begin
        op_s = decode_icode(icode);
        rd   = op_s.rd;
        wr   = op_s.wr;
        if (op_s.asel == ASEL_VALA) begin
            addr = val_a;
        end else begin
            addr = val_e;
        end
        if (op_s.wsel == WSEL_VALP) begin
            wdata = val_p;
        end else begin
            wdata = val_a;
        end
    end
endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle Y86 memory stage: accepts from execute, runs one req/gnt/rvalid access,
// and holds the result for write-back; faults bad addresses and stalled buses as SADR.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 4096,
    parameter int TIMEOUT   = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NIBBLE_W-1:0] icode_i,
    input  logic [DATA_W-1:0]   valA_i,
    input  logic [DATA_W-1:0]   valP_i,
    input  logic [DATA_W-1:0]   valE_i,
    mem_access_unit_if.master   dmem,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NIBBLE_W-1:0] icode_o,
    output logic [DATA_W-1:0]   valE_o,
    output logic [DATA_W-1:0]   valM_o,
    output logic [1:0]          stat_o,
    output logic                stall_o
);
    localparam int BYTES   = DATA_W / 8;
    localparam int ALIGN_W = $clog2(BYTES);
    localparam int CNT_W   = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [DATA_W-1:0] LAST_ADDR = DATA_W'(MEM_BYTES - BYTES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);

    logic [1:0]          state_r, state_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic                req_r, req_nxt_s, we_r, we_nxt_s;
    logic                out_valid_r, out_valid_nxt_s;
    logic [DATA_W-1:0]   addr_r, addr_nxt_s, wdata_r, wdata_nxt_s;
    logic [DATA_W-1:0]   vale_r, vale_nxt_s, valm_r, valm_nxt_s;
    logic [NIBBLE_W-1:0] icode_r, icode_nxt_s;
    logic [1:0]          stat_r, stat_nxt_s;
    logic                dec_rd_s, dec_wr_s, access_s, fault_s, accept_s;
    logic                finish_s, expire_s;
    logic [DATA_W-1:0]   dec_addr_s, dec_wdata_s;

    mem_op_decode #(.DATA_W(DATA_W)) u_decode (
        .icode (icode_i),
        .val_a (valA_i),
        .val_p (valP_i),
        .val_e (valE_i),
        .rd    (dec_rd_s),
        .wr    (dec_wr_s),
        .addr  (dec_addr_s),
        .wdata (dec_wdata_s)
    );

    // Unsigned compare against the last whole word, so addresses near 2^DATA_W fault too.
    assign access_s = dec_rd_s | dec_wr_s;
    assign fault_s  = (dec_addr_s[ALIGN_W-1:0] != '0) || (dec_addr_s > LAST_ADDR);
    assign in_ready = (state_r == ST_IDLE) || ((state_r == ST_DONE) && out_ready);
    assign accept_s = in_valid && in_ready;
    assign stall_o  = ~in_ready;

    // Next-state logic for the access FSM, timeout counter and result registers.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        req_nxt_s       = req_r;
        we_nxt_s        = we_r;
        addr_nxt_s      = addr_r;
        wdata_nxt_s     = wdata_r;
        icode_nxt_s     = icode_r;
        vale_nxt_s      = vale_r;
        valm_nxt_s      = valm_r;
        stat_nxt_s      = stat_r;
        out_valid_nxt_s = out_valid_r;
        finish_s        = 1'b0;
        expire_s        = 1'b0;
        case (state_r)
            ST_REQ: begin
                if (dmem.dmem_gnt && (we_r || dmem.dmem_rvalid)) begin
                    finish_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    expire_s = 1'b1;
                end else if (dmem.dmem_gnt) begin
                    state_nxt_s = ST_WAIT_R;
                    req_nxt_s   = 1'b0;
                end else begin
                    req_nxt_s = 1'b1;
                end
            end
            ST_WAIT_R: begin
                if (dmem.dmem_rvalid) begin
                    finish_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    expire_s = 1'b1;
                end else begin
                    req_nxt_s = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s     = ST_IDLE;
                    out_valid_nxt_s = 1'b0;
                end else begin
                    out_valid_nxt_s = 1'b1;
                end
            end
            ST_IDLE: out_valid_nxt_s = 1'b0;
            default: begin
                state_nxt_s     = ST_IDLE;
                req_nxt_s       = 1'b0;
                out_valid_nxt_s = 1'b0;
            end
        endcase

        // A fresh accept overrides the DONE->IDLE step so back-to-back ops need no bubble.
        if (accept_s) begin
            icode_nxt_s = icode_i;
            vale_nxt_s  = valE_i;
            addr_nxt_s  = dec_addr_s;
            wdata_nxt_s = dec_wdata_s;
            we_nxt_s    = dec_wr_s && !fault_s;
            cnt_nxt_s   = '0;
            valm_nxt_s  = '0;
            if (access_s && !fault_s) begin
                state_nxt_s     = ST_REQ;
                req_nxt_s       = 1'b1;
                out_valid_nxt_s = 1'b0;
                stat_nxt_s      = SAOK;
            end else if (access_s) begin
                state_nxt_s     = ST_DONE;
                req_nxt_s       = 1'b0;
                out_valid_nxt_s = 1'b1;
                stat_nxt_s      = SADR;
            end else begin
                state_nxt_s     = ST_DONE;
                req_nxt_s       = 1'b0;
                out_valid_nxt_s = 1'b1;
                stat_nxt_s      = SAOK;
            end
        end else if (finish_s || expire_s) begin
            state_nxt_s     = ST_DONE;
            req_nxt_s       = 1'b0;
            out_valid_nxt_s = 1'b1;
            if (expire_s) begin
                stat_nxt_s = SADR;
                valm_nxt_s = '0;
            end else if (we_r) begin
                stat_nxt_s = SAOK;
                valm_nxt_s = '0;
            end else begin
                stat_nxt_s = SAOK;
                valm_nxt_s = dmem.dmem_rdata;
            end
        end else if ((state_r == ST_REQ) || (state_r == ST_WAIT_R)) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // State and output registers; reset drops any in-flight access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            req_r       <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            icode_r     <= I_NOP;
            vale_r      <= '0;
            valm_r      <= '0;
            stat_r      <= SAOK;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            req_r       <= req_nxt_s;
            we_r        <= we_nxt_s;
            addr_r      <= addr_nxt_s;
            wdata_r     <= wdata_nxt_s;
            icode_r     <= icode_nxt_s;
            vale_r      <= vale_nxt_s;
            valm_r      <= valm_nxt_s;
            stat_r      <= stat_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

    assign dmem.dmem_req   = req_r;
    assign dmem.dmem_we    = we_r;
    assign dmem.dmem_addr  = addr_r[ADDR_W-1:0];
    assign dmem.dmem_wdata = wdata_r;
    assign out_valid       = out_valid_r;
    assign icode_o         = icode_r;
    assign valE_o          = vale_r;
    assign valM_o          = valm_r;
    assign stat_o          = stat_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Scenario bench for mem_access_unit: expected results are queued at issue and compared on out_valid.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam logic [3:0] T_NOP = 4'h1, T_IRMOVL = 4'h3, T_RMMOVL = 4'h4, T_MRMOVL = 4'h5;
    localparam logic [3:0] T_OPL = 4'h6, T_PUSHL = 4'hA, T_POPL = 4'hB;

    typedef struct packed {
        logic [3:0]  icode;
        logic [31:0] vale;
        logic [31:0] valm;
        logic [1:0]  stat;
    } res_t;

    res_t exp_q[$];
    res_t got, exp_r;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, stall_o;
    logic [3:0]  icode_i, icode_o;
    logic [31:0] valA_i, valP_i, valE_i, valE_o, valM_o;
    logic [1:0]  stat_o;
    int          n_checks = 0;
    int          n_errors = 0;

    mem_access_unit_if #(.DATA_W(32), .ADDR_W(32)) dmem_if ();

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .MEM_BYTES(4096), .TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .icode_i(icode_i), .valA_i(valA_i), .valP_i(valP_i), .valE_i(valE_i),
        .dmem(dmem_if), .out_valid(out_valid), .out_ready(out_ready),
        .icode_o(icode_o), .valE_o(valE_o), .valM_o(valM_o), .stat_o(stat_o), .stall_o(stall_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] ic, input logic [31:0] a, input logic [31:0] p, input logic [31:0] e);
        in_valid = 1'b1;
        icode_i  = ic;
        valA_i   = a;
        valP_i   = p;
        valE_i   = e;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        icode_i = 4'h0; valA_i = 32'h0; valP_i = 32'h0; valE_i = 32'h0;
        dmem_if.dmem_gnt = 1'b0; dmem_if.dmem_rvalid = 1'b0; dmem_if.dmem_rdata = 32'h0;
        tick; tick;
        n_checks++;
        if ({dmem_if.dmem_req, dmem_if.dmem_we, out_valid, in_ready, stall_o} !== 5'b00010) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b expected 00010",
                     {dmem_if.dmem_req, dmem_if.dmem_we, out_valid, in_ready, stall_o});
        end
        got = {icode_o, valE_o, valM_o, stat_o};
        exp_r = {T_NOP, 32'h0, 32'h0, SAOK};
        n_checks++;
        if (got !== exp_r) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected %h", got, exp_r);
        end
        rst = 1'b0;
        tick;
        n_checks++;
        if ({dmem_if.dmem_req, out_valid, in_ready} !== 3'b001) begin
            n_errors++;
            $display("FAIL reset_release: got %b expected 001", {dmem_if.dmem_req, out_valid, in_ready});
        end
    endtask

    task automatic test_read_wait;
        drive(T_MRMOVL, 32'h0, 32'h0, 32'h100);
        exp_q.push_back({T_MRMOVL, 32'h100, 32'hDEADBEEF, SAOK});
        tick;
        in_valid = 1'b0;
        n_checks++;
        if ({dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            n_errors++;
            $display("FAIL read_req: got %h expected %h",
                     {dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr}, {1'b1, 1'b0, 32'h100});
        end
        dmem_if.dmem_gnt = 1'b1;
        tick;
        dmem_if.dmem_gnt = 1'b0;
        tick;
        n_checks++;
        if ({dmem_if.dmem_req, out_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL read_wait: got %b expected 00", {dmem_if.dmem_req, out_valid});
        end
        dmem_if.dmem_rvalid = 1'b1; dmem_if.dmem_rdata = 32'hDEADBEEF;
        tick;
        dmem_if.dmem_rvalid = 1'b0;
        got = {icode_o, valE_o, valM_o, stat_o};
        exp_r = exp_q.pop_front();
        n_checks++;
        if (!out_valid || got !== exp_r) begin
            n_errors++;
            $display("FAIL read_result: valid %b got %h expected %h", out_valid, got, exp_r);
        end
        out_ready = 1'b1; tick; out_ready = 1'b0;
    endtask

    task automatic test_write_and_fast_read;
        drive(T_PUSHL, 32'h55, 32'h77, 32'h1FC);
        exp_q.push_back({T_PUSHL, 32'h1FC, 32'h0, SAOK});
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata} !==
                {1'b1, 1'b1, 32'h1FC, 32'h55}) begin
                n_errors++;
                $display("FAIL write_hold[%0d]: got %h expected %h", i,
                         {dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata},
                         {1'b1, 1'b1, 32'h1FC, 32'h55});
            end
            if (i < 3) tick;
        end
        dmem_if.dmem_gnt = 1'b1;
        tick;
        dmem_if.dmem_gnt = 1'b0;
        got = {icode_o, valE_o, valM_o, stat_o};
        exp_r = exp_q.pop_front();
        n_checks++;
        if (!out_valid || dmem_if.dmem_req || got !== exp_r) begin
            n_errors++;
            $display("FAIL write_result: valid %b req %b got %h expected %h", out_valid, dmem_if.dmem_req, got, exp_r);
        end
        out_ready = 1'b1; tick; out_ready = 1'b0;

        drive(T_POPL, 32'h1FC, 32'h0, 32'h200);
        exp_q.push_back({T_POPL, 32'h200, 32'h12345678, SAOK});
        tick;
        in_valid = 1'b0;
        n_checks++;
        if ({dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr} !== {1'b1, 1'b0, 32'h1FC}) begin
            n_errors++;
            $display("FAIL pop_req: got %h expected %h",
                     {dmem_if.dmem_req, dmem_if.dmem_we, dmem_if.dmem_addr}, {1'b1, 1'b0, 32'h1FC});
        end
        dmem_if.dmem_gnt = 1'b1; dmem_if.dmem_rvalid = 1'b1; dmem_if.dmem_rdata = 32'h12345678;
        tick;
        dmem_if.dmem_gnt = 1'b0; dmem_if.dmem_rvalid = 1'b0;
        got = {icode_o, valE_o, valM_o, stat_o};
        exp_r = exp_q.pop_front();
        n_checks++;
        if (!out_valid || got !== exp_r) begin
            n_errors++;
            $display("FAIL fast_read: valid %b got %h expected %h", out_valid, got, exp_r);
        end
        out_ready = 1'b1; tick; out_ready = 1'b0;
    endtask

    task automatic test_fault;
        logic [3:0]  f_ic[4];
        logic [31:0] f_a[4];
        logic [31:0] f_e[4];
        f_ic = '{T_RMMOVL, T_MRMOVL, T_PUSHL, T_POPL};
        f_a  = '{32'h11, 32'h0, 32'h22, 32'h1004};
        f_e  = '{32'h102, 32'h1000, 32'hFFFF_FFFC, 32'h100};
        for (int i = 0; i < 4; i++) begin
            drive(f_ic[i], f_a[i], 32'h0, f_e[i]);
            exp_q.push_back({f_ic[i], f_e[i], 32'h0, SADR});
            tick;
            in_valid = 1'b0;
            got = {icode_o, valE_o, valM_o, stat_o};
            exp_r = exp_q.pop_front();
            n_checks++;
            if (dmem_if.dmem_req || !out_valid || got !== exp_r) begin
                n_errors++;
                $display("FAIL fault[%0d]: req %b valid %b got %h expected %h", i, dmem_if.dmem_req, out_valid, got, exp_r);
            end
            out_ready = 1'b1; tick; out_ready = 1'b0;
        end
        drive(T_MRMOVL, 32'h0, 32'h0, 32'hFFC);
        exp_q.push_back({T_MRMOVL, 32'hFFC, 32'hCAFEF00D, SAOK});
        tick;
        in_valid = 1'b0;
        n_checks++;
        if ({dmem_if.dmem_req, dmem_if.dmem_addr} !== {1'b1, 32'hFFC}) begin
            n_errors++;
            $display("FAIL last_word_req: got %h expected %h", {dmem_if.dmem_req, dmem_if.dmem_addr}, {1'b1, 32'hFFC});
        end
        dmem_if.dmem_gnt = 1'b1; dmem_if.dmem_rvalid = 1'b1; dmem_if.dmem_rdata = 32'hCAFEF00D;
        tick;
        dmem_if.dmem_gnt = 1'b0; dmem_if.dmem_rvalid = 1'b0;
        got = {icode_o, valE_o, valM_o, stat_o};
        exp_r = exp_q.pop_front();
        n_checks++;
        if (!out_valid || got !== exp_r) begin
            n_errors++;
            $display("FAIL last_word_result: valid %b got %h expected %h", out_valid, got, exp_r);
        end
        out_ready = 1'b1; tick; out_ready = 1'b0;
    endtask

    task automatic test_timeout;
        int cyc;
        drive(T_MRMOVL, 32'h0, 32'h0, 32'h200);
        exp_q.push_back({T_MRMOVL, 32'h200, 32'h0, SADR});
        tick;
        in_valid = 1'b0;
        dmem_if.dmem_gnt = 1'b1;
        tick;
        dmem_if.dmem_gnt = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 400) begin
            tick;
            cyc++;
        end
        n_checks++;
        if (!out_valid || cyc != 255) begin
            n_errors++;
            $display("FAIL timeout_latency: valid %b cycles %0d expected 255", out_valid, cyc);
        end
        dmem_if.dmem_rvalid = 1'b1; dmem_if.dmem_rdata = 32'hBAD0BAD0;
        tick;
        dmem_if.dmem_rvalid = 1'b0;
        got = {icode_o, valE_o, valM_o, stat_o};
        exp_r = exp_q.pop_front();
        n_checks++;
        if (!out_valid || dmem_if.dmem_req || got !== exp_r) begin
            n_errors++;
            $display("FAIL timeout_result: valid %b req %b got %h expected %h", out_valid, dmem_if.dmem_req, got, exp_r);
        end
        out_ready = 1'b1; tick; out_ready = 1'b0;
        dmem_if.dmem_rvalid = 1'b1; dmem_if.dmem_rdata = 32'h0BAD_0BAD;
        tick;
        dmem_if.dmem_rvalid = 1'b0;
        n_checks++;
        if ({out_valid, valM_o} !== {1'b0, 32'h0}) begin
            n_errors++;
            $display("FAIL idle_rvalid: got %h expected %h", {out_valid, valM_o}, {1'b0, 32'h0});
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  ic;
        logic [31:0] ve;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ic = (i % 2 == 0) ? T_OPL : T_IRMOVL;
            ve = $urandom;
            drive(ic, $urandom, $urandom, ve);
            exp_q.push_back({ic, ve, 32'h0, SAOK});
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready);
            end
            tick;
            got = {icode_o, valE_o, valM_o, stat_o};
            n_checks++;
            if (!out_valid || got !== exp_q[0]) begin
                n_errors++;
                $display("FAIL stream[%0d]: valid %b got %h expected %h", i, out_valid, got, exp_q[0]);
            end
            if (i < 3) void'(exp_q.pop_front());
        end
        out_ready = 1'b0;
        ve = 32'h0000_0ABC;
        drive(T_OPL, 32'h1, 32'h2, ve);
        exp_q.push_back({T_OPL, ve, 32'h0, SAOK});
        for (int i = 0; i < 3; i++) begin
            tick;
            got = {icode_o, valE_o, valM_o, stat_o};
            n_checks++;
            if ({stall_o, in_ready, out_valid} !== 3'b101 || got !== exp_q[0]) begin
                n_errors++;
                $display("FAIL hold[%0d]: ctrl %b got %h expected %h", i, {stall_o, in_ready, out_valid}, got, exp_q[0]);
            end
        end
        out_ready = 1'b1;
        tick;
        void'(exp_q.pop_front());
        in_valid = 1'b0;
        got = {icode_o, valE_o, valM_o, stat_o};
        exp_r = exp_q.pop_front();
        n_checks++;
        if (!out_valid || got !== exp_r) begin
            n_errors++;
            $display("FAIL resume: valid %b got %h expected %h", out_valid, got, exp_r);
        end
        tick;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL drain: out_valid %b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid_req;
        drive(T_MRMOVL, 32'h0, 32'h0, 32'h300);
        tick;
        in_valid = 1'b0;
        n_checks++;
        if (dmem_if.dmem_req !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_req_setup: req %b expected 1", dmem_if.dmem_req);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({dmem_if.dmem_req, out_valid, in_ready} !== 3'b001) begin
            n_errors++;
            $display("FAIL mid_req_reset: got %b expected 001", {dmem_if.dmem_req, out_valid, in_ready});
        end
        tick;
        rst = 1'b0;
        dmem_if.dmem_gnt = 1'b1; dmem_if.dmem_rvalid = 1'b1; dmem_if.dmem_rdata = 32'h5A5A5A5A;
        tick; tick;
        dmem_if.dmem_gnt = 1'b0; dmem_if.dmem_rvalid = 1'b0;
        n_checks++;
        if ({dmem_if.dmem_req, out_valid, valM_o} !== {1'b0, 1'b0, 32'h0}) begin
            n_errors++;
            $display("FAIL mid_req_discard: got %h expected 0", {dmem_if.dmem_req, out_valid, valM_o});
        end
    endtask

    initial begin
        test_reset;
        test_read_wait;
        test_write_and_fast_read;
        test_fault;
        test_timeout;
        test_back_to_back;
        test_reset_mid_req;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_empty: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
